reg_file_sb: RTL and testbench

//  Parametrised CPU register file: 2 async read ports, 1 sync write port,

---
 rtl/cpu_pkg.sv | 15 +
 rtl/reg_scoreboard.sv | 52 +++++
 rtl/reg_file_sb.sv | 78 +++++++
 tb/tb_reg_file_sb.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default register-file geometry and index helpers.
package cpu_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_REGS = 4;
  localparam int ZERO_IDX     = 0;

  typedef logic [$clog2(DEF_NUM_REGS)-1:0] reg_idx_t;

  // True when idx names a real register that can hold a value.
  function automatic bit idx_live(input int idx, input int num_regs, input bit zero_reg);
    return (idx < num_regs) && !(zero_reg && (idx == ZERO_IDX));
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending scoreboard with busy lookup for two operand ports.
module reg_scoreboard
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic                IssueValid,
  input  logic [ADDR_W-1:0]   IssueRD,
  input  logic                RegWrite,
  input  logic [ADDR_W-1:0]   RD,
  input  logic [ADDR_W-1:0]   RS,
  input  logic [ADDR_W-1:0]   RT,
  output logic                RS_Busy,
  output logic                RT_Busy,
  output logic [NUM_REGS-1:0] PendingMask
);

  logic [NUM_REGS-1:0] pend_next;
  logic                issue_ok;
  logic                clear_ok;

  // Next pending state: writeback clears, issue sets, and a new producer wins a tie.
  always_comb begin
    issue_ok  = IssueValid && idx_live(int'(IssueRD), NUM_REGS, ZERO_REG);
    clear_ok  = RegWrite && idx_live(int'(RD), NUM_REGS, ZERO_REG);
    pend_next = PendingMask;
    if (clear_ok) pend_next[RD] = 1'b0;
    if (issue_ok) pend_next[IssueRD] = 1'b1;
  end

  // Pending bits register; reset drops every outstanding producer.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) PendingMask <= '0;
    else          PendingMask <= pend_next;
  end

  // An operand is busy while pending unless its producer is writing back right now.
  always_comb begin
    RS_Busy = 1'b0;
    RT_Busy = 1'b0;
    if (idx_live(int'(RS), NUM_REGS, ZERO_REG))
      RS_Busy = PendingMask[RS] && !(BYPASS && RegWrite && (RD == RS));
    if (idx_live(int'(RT), NUM_REGS, ZERO_REG))
      RT_Busy = PendingMask[RT] && !(BYPASS && RegWrite && (RD == RT));
  end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with two async read ports, one sync write port, bypass and scoreboard.
module reg_file_sb
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic [ADDR_W-1:0]   RS,
  input  logic [ADDR_W-1:0]   RT,
  output logic [DATA_W-1:0]   ReadRS,
  output logic [DATA_W-1:0]   ReadRT,
  input  logic [ADDR_W-1:0]   RD,
  input  logic [DATA_W-1:0]   WriteData,
  input  logic                RegWrite,
  input  logic                IssueValid,
  input  logic [ADDR_W-1:0]   IssueRD,
  output logic                RS_Busy,
  output logic                RT_Busy,
  output logic                Hazard,
  output logic [NUM_REGS-1:0] PendingMask
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_legal;
  logic              fwd_ok;

  // A write only lands on a real, writable register; forwarding also needs reset released.
  always_comb begin
    wr_legal = RegWrite && idx_live(int'(RD), NUM_REGS, ZERO_REG);
    fwd_ok   = BYPASS && wr_legal && Reset_n;
  end

  // Register storage; a write coinciding with reset is discarded.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_legal) begin
      regs[RD] <= WriteData;
    end
  end

  // Read ports: dead indices read zero, a matching writeback is forwarded.
  always_comb begin
    ReadRS = '0;
    ReadRT = '0;
    if (idx_live(int'(RS), NUM_REGS, ZERO_REG))
      ReadRS = (fwd_ok && (RD == RS)) ? WriteData : regs[RS];
    if (idx_live(int'(RT), NUM_REGS, ZERO_REG))
      ReadRT = (fwd_ok && (RD == RT)) ? WriteData : regs[RT];
  end

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_scoreboard (
    .Clock       (Clock),
    .Reset_n     (Reset_n),
    .IssueValid  (IssueValid),
    .IssueRD     (IssueRD),
    .RegWrite    (RegWrite),
    .RD          (RD),
    .RS          (RS),
    .RT          (RT),
    .RS_Busy     (RS_Busy),
    .RT_Busy     (RT_Busy),
    .PendingMask (PendingMask)
  );

  assign Hazard = RS_Busy | RT_Busy;

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench: default build, BYPASS=0 build, and ZERO_REG=1/NUM_REGS=6 build.
module tb_reg_file_sb;
  import cpu_pkg::*;

  logic Clock = 1'b0;
  logic Reset_n;

  // Clock generator, 10 time-unit period.
  always #5 Clock = ~Clock;

  // Stimulus shared by the default and no-bypass builds
  reg_idx_t    rs, rt, rd, issuerd;
  logic [15:0] wdata;
  logic        regwrite, issuevalid;

  logic [15:0] a_rs, a_rt, b_rs, b_rt;
  logic        a_rsb, a_rtb, a_haz, b_rsb, b_rtb, b_haz;
  logic [3:0]  a_mask, b_mask;

  // Stimulus for the zero-register build
  logic [2:0]  zrs, zrt, zrd, zissuerd;
  logic [15:0] zwdata;
  logic        zregwrite, zissuevalid;

  logic [15:0] z_rs, z_rt;
  logic        z_rsb, z_rtb, z_haz;
  logic [5:0]  z_mask;

  // Reference model state
  logic [15:0] m_regs [4];
  bit          m_pend [4];
  logic [15:0] mz_regs [6];
  bit          mz_pend [6];

  int checks = 0;
  int fails  = 0;

  reg_file_sb dut (
    .Clock(Clock), .Reset_n(Reset_n), .RS(rs), .RT(rt), .ReadRS(a_rs), .ReadRT(a_rt),
    .RD(rd), .WriteData(wdata), .RegWrite(regwrite), .IssueValid(issuevalid), .IssueRD(issuerd),
    .RS_Busy(a_rsb), .RT_Busy(a_rtb), .Hazard(a_haz), .PendingMask(a_mask)
  );

  reg_file_sb #(.BYPASS(1'b0)) dut_nb (
    .Clock(Clock), .Reset_n(Reset_n), .RS(rs), .RT(rt), .ReadRS(b_rs), .ReadRT(b_rt),
    .RD(rd), .WriteData(wdata), .RegWrite(regwrite), .IssueValid(issuevalid), .IssueRD(issuerd),
    .RS_Busy(b_rsb), .RT_Busy(b_rtb), .Hazard(b_haz), .PendingMask(b_mask)
  );

  reg_file_sb #(.NUM_REGS(6), .ZERO_REG(1'b1)) dut_z (
    .Clock(Clock), .Reset_n(Reset_n), .RS(zrs), .RT(zrt), .ReadRS(z_rs), .ReadRT(z_rt),
    .RD(zrd), .WriteData(zwdata), .RegWrite(zregwrite), .IssueValid(zissuevalid), .IssueRD(zissuerd),
    .RS_Busy(z_rsb), .RT_Busy(z_rtb), .Hazard(z_haz), .PendingMask(z_mask)
  );

  // ---------------- reference model ----------------
  function automatic logic [15:0] exp_read(input int x, input bit bypass);
    if (bypass && regwrite && (int'(rd) == x)) return wdata;
    return m_regs[x];
  endfunction

  function automatic bit exp_busy(input int x, input bit bypass);
    return m_pend[x] && !(bypass && regwrite && (int'(rd) == x));
  endfunction

  function automatic logic [3:0] exp_mask();
    logic [3:0] m;
    for (int i = 0; i < 4; i++) m[i] = m_pend[i];
    return m;
  endfunction

  function automatic bit z_live(input int x);
    return (x >= 1) && (x <= 5);
  endfunction

  function automatic logic [15:0] exp_zread(input int x);
    if (!z_live(x)) return 16'h0000;
    if (zregwrite && (int'(zrd) == x)) return zwdata;
    return mz_regs[x];
  endfunction

  function automatic bit exp_zbusy(input int x);
    if (!z_live(x)) return 1'b0;
    return mz_pend[x] && !(zregwrite && (int'(zrd) == x));
  endfunction

  function automatic logic [5:0] exp_zmask();
    logic [5:0] m;
    for (int i = 0; i < 6; i++) m[i] = mz_pend[i];
    return m;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin m_regs[i] = '0; m_pend[i] = 0; end
    for (int i = 0; i < 6; i++) begin mz_regs[i] = '0; mz_pend[i] = 0; end
  endtask

  // One rising edge; the model takes the inputs that were stable across it.
  task automatic tick();
    @(posedge Clock);
    if (Reset_n) begin
      if (regwrite) begin m_regs[rd] = wdata; m_pend[rd] = 0; end
      if (issuevalid) m_pend[issuerd] = 1;
      if (zregwrite && z_live(int'(zrd))) begin mz_regs[zrd] = zwdata; mz_pend[zrd] = 0; end
      if (zissuevalid && z_live(int'(zissuerd))) mz_pend[zissuerd] = 1;
    end
    #1;
  endtask

  task automatic idle();
    rs = '0; rt = '0; rd = '0; issuerd = '0; wdata = '0; regwrite = 0; issuevalid = 0;
    zrs = '0; zrt = '0; zrd = '0; zissuerd = '0; zwdata = '0; zregwrite = 0; zissuevalid = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle();
    Reset_n = 1'b1;
    #2 Reset_n = 1'b0;
    rs = 2'd1; rt = 2'd2;
    #1;
    checks++; if (a_rs !== 16'h0) begin fails++; $display("[TB] FAIL reset_read_rs got=%h exp=0000", a_rs); end
    checks++; if (a_rt !== 16'h0) begin fails++; $display("[TB] FAIL reset_read_rt got=%h exp=0000", a_rt); end
    checks++; if (a_mask !== 4'h0) begin fails++; $display("[TB] FAIL reset_mask got=%b exp=0000", a_mask); end
    checks++; if (a_haz !== 1'b0) begin fails++; $display("[TB] FAIL reset_hazard got=%b exp=0", a_haz); end
    checks++; if (z_mask !== 6'h0) begin fails++; $display("[TB] FAIL reset_zmask got=%b exp=000000", z_mask); end
    model_clear();
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset_n = 1'b1;
  endtask

  task automatic test_write_read();
    @(negedge Clock);
    idle(); rd = 2'd2; wdata = 16'h0007; regwrite = 1;
    tick();
    @(negedge Clock);
    idle(); rs = 2'd2; rt = 2'd3;
    #1;
    checks++; if (a_rs !== 16'h0007) begin fails++; $display("[TB] FAIL wr_read_rs got=%h exp=0007", a_rs); end
    checks++; if (a_rt !== 16'h0000) begin fails++; $display("[TB] FAIL wr_read_rt got=%h exp=0000", a_rt); end
    checks++; if (b_rs !== 16'h0007) begin fails++; $display("[TB] FAIL wr_read_rs_nb got=%h exp=0007", b_rs); end
  endtask

  task automatic test_bypass();
    @(negedge Clock);
    idle(); rd = 2'd1; wdata = 16'd5; regwrite = 1;
    tick();
    @(negedge Clock);
    idle(); rd = 2'd1; wdata = 16'd9; regwrite = 1; rs = 2'd1;
    #1;
    checks++; if (a_rs !== 16'd9) begin fails++; $display("[TB] FAIL bypass_before got=%h exp=0009", a_rs); end
    checks++; if (b_rs !== 16'd5) begin fails++; $display("[TB] FAIL nobypass_before got=%h exp=0005", b_rs); end
    tick();
    checks++; if (a_rs !== 16'd9) begin fails++; $display("[TB] FAIL bypass_after got=%h exp=0009", a_rs); end
    checks++; if (b_rs !== 16'd9) begin fails++; $display("[TB] FAIL nobypass_after got=%h exp=0009", b_rs); end
  endtask

  task automatic test_scoreboard();
    @(negedge Clock);
    idle(); issuevalid = 1; issuerd = 2'd3;
    tick();
    checks++; if (a_mask !== 4'b1000) begin fails++; $display("[TB] FAIL sb_issue_mask got=%b exp=1000", a_mask); end
    @(negedge Clock);
    idle(); rs = 2'd3;
    #1;
    checks++; if (a_rsb !== 1'b1) begin fails++; $display("[TB] FAIL sb_rs_busy got=%b exp=1", a_rsb); end
    checks++; if (a_haz !== 1'b1) begin fails++; $display("[TB] FAIL sb_hazard got=%b exp=1", a_haz); end
    @(negedge Clock);
    idle(); rs = 2'd3; rd = 2'd3; wdata = 16'h00AB; regwrite = 1;
    #1;
    checks++; if (a_rsb !== 1'b0) begin fails++; $display("[TB] FAIL sb_wb_busy got=%b exp=0", a_rsb); end
    checks++; if (b_rsb !== 1'b1) begin fails++; $display("[TB] FAIL sb_wb_busy_nb got=%b exp=1", b_rsb); end
    tick();
    checks++; if (a_mask !== 4'b0000) begin fails++; $display("[TB] FAIL sb_clear_mask got=%b exp=0000", a_mask); end
  endtask

  task automatic test_set_vs_clear();
    @(negedge Clock);
    idle(); issuevalid = 1; issuerd = 2'd2; regwrite = 1; rd = 2'd2; wdata = 16'h1234;
    tick();
    checks++; if (a_mask !== 4'b0100) begin fails++; $display("[TB] FAIL set_wins_mask got=%b exp=0100", a_mask); end
  endtask

  task automatic test_zero_reg();
    @(negedge Clock);
    idle(); zregwrite = 1; zrd = 3'd0; zwdata = 16'hFFFF; zissuevalid = 1; zissuerd = 3'd0; zrs = 3'd0;
    #1;
    checks++; if (z_rs !== 16'h0) begin fails++; $display("[TB] FAIL zero_read_during got=%h exp=0000", z_rs); end
    tick();
    checks++; if (z_mask !== 6'h0) begin fails++; $display("[TB] FAIL zero_issue_mask got=%b exp=000000", z_mask); end
    @(negedge Clock);
    idle(); zrs = 3'd0;
    #1;
    checks++; if (z_rs !== 16'h0) begin fails++; $display("[TB] FAIL zero_read_after got=%h exp=0000", z_rs); end
    zrs = 3'd7;
    #1;
    checks++; if (z_rs !== 16'h0) begin fails++; $display("[TB] FAIL oor_read got=%h exp=0000", z_rs); end
    checks++; if (z_rsb !== 1'b0) begin fails++; $display("[TB] FAIL oor_busy got=%b exp=0", z_rsb); end
  endtask

  task automatic test_random();
    logic [15:0] er;
    bit          bs, bt;
    for (int i = 0; i < 150; i++) begin
      @(negedge Clock);
      idle();
      rs = 2'($urandom_range(0, 3)); rt = 2'($urandom_range(0, 3));
      rd = 2'($urandom_range(0, 3)); issuerd = 2'($urandom_range(0, 3));
      wdata = 16'($urandom); regwrite = 1'($urandom_range(0, 1)); issuevalid = ($urandom_range(0, 2) == 0);
      #1;
      er = exp_read(int'(rs), 1);
      checks++; if (a_rs !== er) begin fails++; $display("[TB] FAIL rand_rs cyc=%0d got=%h exp=%h", i, a_rs, er); end
      er = exp_read(int'(rt), 1);
      checks++; if (a_rt !== er) begin fails++; $display("[TB] FAIL rand_rt cyc=%0d got=%h exp=%h", i, a_rt, er); end
      er = exp_read(int'(rs), 0);
      checks++; if (b_rs !== er) begin fails++; $display("[TB] FAIL rand_rs_nb cyc=%0d got=%h exp=%h", i, b_rs, er); end
      bs = exp_busy(int'(rs), 1); bt = exp_busy(int'(rt), 1);
      checks++; if (a_rsb !== bs) begin fails++; $display("[TB] FAIL rand_rs_busy cyc=%0d got=%b exp=%b", i, a_rsb, bs); end
      checks++; if (a_rtb !== bt) begin fails++; $display("[TB] FAIL rand_rt_busy cyc=%0d got=%b exp=%b", i, a_rtb, bt); end
      checks++; if (a_haz !== (bs | bt)) begin fails++; $display("[TB] FAIL rand_hazard cyc=%0d got=%b exp=%b", i, a_haz, bs | bt); end
      bs = exp_busy(int'(rs), 0);
      checks++; if (b_rsb !== bs) begin fails++; $display("[TB] FAIL rand_rs_busy_nb cyc=%0d got=%b exp=%b", i, b_rsb, bs); end
      tick();
      checks++; if (a_mask !== exp_mask()) begin fails++; $display("[TB] FAIL rand_mask cyc=%0d got=%b exp=%b", i, a_mask, exp_mask()); end
    end
  endtask

  task automatic test_random_zero();
    logic [15:0] er;
    bit          bs;
    for (int i = 0; i < 150; i++) begin
      @(negedge Clock);
      idle();
      zrs = 3'($urandom_range(0, 7)); zrt = 3'($urandom_range(0, 7));
      zrd = 3'($urandom_range(0, 7)); zissuerd = 3'($urandom_range(0, 7));
      zwdata = 16'($urandom); zregwrite = 1'($urandom_range(0, 1)); zissuevalid = 1'($urandom_range(0, 1));
      #1;
      er = exp_zread(int'(zrs));
      checks++; if (z_rs !== er) begin fails++; $display("[TB] FAIL zrand_rs cyc=%0d got=%h exp=%h", i, z_rs, er); end
      er = exp_zread(int'(zrt));
      checks++; if (z_rt !== er) begin fails++; $display("[TB] FAIL zrand_rt cyc=%0d got=%h exp=%h", i, z_rt, er); end
      bs = exp_zbusy(int'(zrs));
      checks++; if (z_rsb !== bs) begin fails++; $display("[TB] FAIL zrand_rs_busy cyc=%0d got=%b exp=%b", i, z_rsb, bs); end
      bs = exp_zbusy(int'(zrs)) | exp_zbusy(int'(zrt));
      checks++; if (z_haz !== bs) begin fails++; $display("[TB] FAIL zrand_hazard cyc=%0d got=%b exp=%b", i, z_haz, bs); end
      tick();
      checks++; if (z_mask !== exp_zmask()) begin fails++; $display("[TB] FAIL zrand_mask cyc=%0d got=%b exp=%b", i, z_mask, exp_zmask()); end
    end
  endtask

  task automatic test_reset_midop();
    @(negedge Clock);
    idle(); rd = 2'd1; wdata = 16'hAAAA; regwrite = 1; issuevalid = 1; issuerd = 2'd2; rs = 2'd1; rt = 2'd2;
    #2 Reset_n = 1'b0;
    #1;
    checks++; if (a_rs !== 16'h0) begin fails++; $display("[TB] FAIL midrst_read_rs got=%h exp=0000", a_rs); end
    checks++; if (a_mask !== 4'h0) begin fails++; $display("[TB] FAIL midrst_mask got=%b exp=0000", a_mask); end
    checks++; if (a_haz !== 1'b0) begin fails++; $display("[TB] FAIL midrst_hazard got=%b exp=0", a_haz); end
    model_clear();
    tick();
    @(negedge Clock);
    idle();
    Reset_n = 1'b1;
    for (int r = 0; r < 4; r++) begin
      rs = 2'(r);
      #1;
      checks++; if (a_rs !== 16'h0) begin fails++; $display("[TB] FAIL midrst_reg%0d got=%h exp=0000", r, a_rs); end
    end
    checks++; if (a_mask !== 4'h0) begin fails++; $display("[TB] FAIL midrst_mask_after got=%b exp=0000", a_mask); end
  endtask

  // Run the scenarios in sequence and report.
  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_set_vs_clear();
    test_zero_reg();
    test_random();
    test_random_zero();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
